// File: rtl/psram_pkg.sv
// Shared FSM state type, opcodes and default latencies for the OPI PSRAM slave.
package psram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInst,
        StAddr,
        StLatn,
        StWdata,
        StRdata,
        StHold
    } state_e;

    localparam logic [7:0] OpWrite   = 8'h80;
    localparam logic [7:0] OpRead    = 8'h00;
    localparam logic [7:0] OpMrWrite = 8'hC0;
    localparam logic [7:0] OpMrRead  = 8'h40;

    localparam int unsigned DefRdLat = 5;
    localparam int unsigned DefWrLat = 5;

endpackage

// File: rtl/psram_slv_mem.sv
// Byte array behind the PSRAM slave: asynchronous read, synchronous write, no reset.
module psram_slv_mem #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [2**AW];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/psram_opi_slv.sv
// Octal (OPI) DDR PSRAM slave, oversampling sck with clk_i.
// Optional mode-register file enabled by defining PSRAM_SLV_MR_EN.
module psram_opi_slv
    import psram_pkg::*;
#(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned RD_LAT = DefRdLat,
    parameter int unsigned WR_LAT = DefWrLat,
    parameter logic [7:0]  WCMD   = OpWrite,
    parameter logic [7:0]  RCMD   = OpRead
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_in_i,
    input  logic       psram_dqs_in_i,
    output logic [7:0] psram_io_out_o,
    output logic [7:0] psram_io_en_o,
    output logic       psram_dqs_out_o,
    output logic       psram_dqs_en_o
);

    localparam logic [7:0] RdLat = 8'(RD_LAT);
    localparam logic [7:0] WrLat = 8'(WR_LAT);

    state_e            state_q;
    logic              sck_q, ce_q, is_rd_q;
    logic [7:0]        op_q, cnt_q, lat_q;
    logic [MEM_AW-1:0] ptr_q;

    logic       rise, fall, edge_v, wr_edge, mem_we;
    logic       op_rd, op_wr;
    logic [7:0] op_lat, mem_rdata, rd_byte;
    state_e     data_st;

    assign rise    = psram_sck_i & ~sck_q;
    assign fall    = ~psram_sck_i & sck_q;
    assign edge_v  = rise | fall;
    assign data_st = is_rd_q ? StRdata : StWdata;
    assign wr_edge = (state_q == StWdata) & edge_v & ~psram_ce_i & ~psram_dqs_in_i;

`ifdef PSRAM_SLV_MR_EN
    logic       mr_sel_q;
    logic       op_mr;
    logic [7:0] mr_q [8];

    always_comb begin
        op_mr  = (op_q == OpMrRead) || (op_q == OpMrWrite);
        op_rd  = op_mr ? (op_q == OpMrRead) : (op_q == RCMD);
        op_wr  = op_mr ? (op_q == OpMrWrite) : (op_q == WCMD);
        op_lat = op_mr ? 8'd0 : (op_rd ? RdLat : WrLat);
    end

    assign rd_byte = mr_sel_q ? mr_q[ptr_q[2:0]] : mem_rdata;
    assign mem_we  = wr_edge & ~mr_sel_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 8; i++) begin
                mr_q[i] <= '0;
            end
        end else if (wr_edge && mr_sel_q) begin
            mr_q[ptr_q[2:0]] <= psram_io_in_i;
        end
    end
`else
    always_comb begin
        op_rd  = (op_q == RCMD);
        op_wr  = (op_q == WCMD);
        op_lat = op_rd ? RdLat : WrLat;
    end

    assign rd_byte = mem_rdata;
    assign mem_we  = wr_edge;
`endif

    psram_slv_mem #(
        .AW(MEM_AW)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .addr_i (ptr_q),
        .wdata_i(psram_io_in_i),
        .rdata_o(mem_rdata)
    );

    // Latency ends on the fall after the last counted rise, so the first data byte
    // always lands on a rising edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= StIdle;
            sck_q           <= 1'b0;
            ce_q            <= 1'b0;
            is_rd_q         <= 1'b0;
            op_q            <= '0;
            cnt_q           <= '0;
            lat_q           <= '0;
            ptr_q           <= '0;
            psram_io_out_o  <= '0;
            psram_io_en_o   <= '0;
            psram_dqs_out_o <= 1'b0;
            psram_dqs_en_o  <= 1'b0;
`ifdef PSRAM_SLV_MR_EN
            mr_sel_q        <= 1'b0;
`endif
        end else begin
            sck_q <= psram_sck_i;
            ce_q  <= psram_ce_i;
            if (psram_ce_i) begin
                state_q        <= StIdle;
                cnt_q          <= '0;
                psram_io_en_o  <= '0;
                psram_dqs_en_o <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // ce_q starts low after reset so a burst needs a real falling ce
                        if (ce_q) begin
                            state_q <= StInst;
                            cnt_q   <= '0;
                        end
                    end
                    StInst: begin
                        if (edge_v) begin
                            if (cnt_q == 8'd0) begin
                                op_q  <= psram_io_in_i;
                                cnt_q <= 8'd1;
                            end else begin
                                cnt_q   <= '0;
                                is_rd_q <= op_rd;
                                lat_q   <= op_lat;
                                state_q <= (op_rd || op_wr) ? StAddr : StHold;
`ifdef PSRAM_SLV_MR_EN
                                mr_sel_q <= op_mr;
`endif
                            end
                        end
                    end
                    StAddr: begin
                        if (edge_v) begin
                            ptr_q <= MEM_AW'({ptr_q, psram_io_in_i});
                            if (cnt_q == 8'd3) begin
                                cnt_q <= '0;
                                if (lat_q == 8'd0) begin
                                    state_q        <= data_st;
                                    psram_io_en_o  <= {8{is_rd_q}};
                                    psram_dqs_en_o <= is_rd_q;
                                end else begin
                                    state_q <= StLatn;
                                end
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                    StLatn: begin
                        if (rise) begin
                            cnt_q <= cnt_q + 8'd1;
                        end else if (fall && cnt_q == lat_q) begin
                            state_q        <= data_st;
                            psram_io_en_o  <= {8{is_rd_q}};
                            psram_dqs_en_o <= is_rd_q;
                        end
                    end
                    StWdata: begin
                        if (edge_v) begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                    StRdata: begin
                        if (edge_v) begin
                            psram_io_out_o  <= rd_byte;
                            psram_dqs_out_o <= rise;
                            ptr_q           <= ptr_q + 1'b1;
                        end
                    end
                    StHold: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_opi_slv.sv
// Self-checking bench for psram_opi_slv: directed bursts plus randomized traffic vs a byte model.
module tb_psram_opi_slv;

    localparam int MEM = 1024;
    localparam int LAT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck, ce, dqs_in;
    logic [7:0] io_in;
    logic [7:0] io_out, io_en;
    logic       dqs_out, dqs_en;

    always #5 clk = ~clk;

    psram_opi_slv dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce),
        .psram_io_in_i  (io_in),
        .psram_dqs_in_i (dqs_in),
        .psram_io_out_o (io_out),
        .psram_io_en_o  (io_en),
        .psram_dqs_out_o(dqs_out),
        .psram_dqs_en_o (dqs_en)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_mem [MEM];
    logic [7:0] wbuf [16];
    logic       mbuf [16];

    logic       exp_en  = 1'b0;
    logic       exp_val = 1'b0;
    logic [7:0] exp_out = '0;
    logic       exp_dqs = 1'b0;
    logic       new_byte = 1'b0;
    logic [8:0] cap_q [$];
    logic [8:0] want [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Output checker: enables every cycle, data only while a read byte is expected.
    always @(posedge clk) begin
        #1;
        chk("io_en", {24'd0, io_en}, {24'd0, {8{exp_en}}});
        chk("dqs_en", {31'd0, dqs_en}, {31'd0, exp_en});
        if (exp_val) begin
            chk("io_out", {24'd0, io_out}, {24'd0, exp_out});
            chk("dqs_out", {31'd0, dqs_out}, {31'd0, exp_dqs});
        end
        if (new_byte) begin
            cap_q.push_back({dqs_out, io_out});
            new_byte = 1'b0;
        end
    end

    task automatic wait_half();
        repeat (4) @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic [7:0] d, input logic m);
        sck = s;
        io_in = d;
        dqs_in = m;
    endtask

    // One full burst; abort_addr < 4 raises ce after that many address bytes,
    // rst_at < n pulls reset just before that data byte.
    task automatic txn(input logic [7:0] op, input logic [31:0] addr, input int n,
                       input int abort_addr, input int rst_at);
        int unsigned p;
        logic rd, wr, s;
        rd = (op == 8'h00);
        wr = (op == 8'h80);
        ce = 1'b0;
        wait_half();
        drive(1'b1, op, 1'b0); wait_half();
        drive(1'b0, op, 1'b0); wait_half();
        for (int i = 0; i < 4; i++) begin
            if (i == abort_addr) begin
                ce = 1'b1; exp_en = 1'b0; wait_half();
                return;
            end
            drive((i % 2) == 0, addr[31-8*i -: 8], 1'b0); wait_half();
        end
        for (int i = 0; i < LAT; i++) begin
            drive(1'b1, 8'($urandom), 1'b0); wait_half();
            drive(1'b0, 8'($urandom), 1'b0);
            if (i == LAT - 1 && rd) exp_en = 1'b1;
            wait_half();
        end
        p = addr % MEM;
        for (int i = 0; i < n; i++) begin
            s = (i % 2) == 0;
            if (i == rst_at) begin
                rst_n = 1'b0; ce = 1'b1; sck = 1'b0;
                exp_en = 1'b0; exp_val = 1'b0; new_byte = 1'b0;
                #1;
                chk("rst_mid_io_en", {24'd0, io_en}, 32'd0);
                chk("rst_mid_dqs_en", {31'd0, dqs_en}, 32'd0);
                chk("rst_mid_io_out", {24'd0, io_out}, 32'd0);
                wait_half();
                rst_n = 1'b1;
                wait_half();
                return;
            end
            drive(s, wbuf[i], mbuf[i]);
            if (wr && !mbuf[i]) model_mem[p] = wbuf[i];
            if (rd) begin
                exp_out = model_mem[p]; exp_dqs = s; exp_val = 1'b1; new_byte = 1'b1;
            end
            p = (p + 1) % MEM;
            wait_half();
        end
        // For odd lengths this sck fall coincides with ce rising and must be ignored
        ce = 1'b1; sck = 1'b0; exp_en = 1'b0; exp_val = 1'b0;
        wait_half();
    endtask

    task automatic set_w(input logic [7:0] a, b, c, d, input logic [3:0] m);
        wbuf[0] = a; wbuf[1] = b; wbuf[2] = c; wbuf[3] = d;
        for (int i = 0; i < 4; i++) mbuf[i] = m[i];
        for (int i = 4; i < 16; i++) mbuf[i] = 1'b0;
    endtask

    task automatic chk_cap(input string name);
        chk({name, "_len"}, cap_q.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            if (i < cap_q.size()) chk(name, {23'd0, cap_q[i]}, {23'd0, want[i]});
        end
        cap_q.delete();
        want.delete();
    endtask

    task automatic read_cap(input logic [31:0] addr, input int n);
        cap_q.delete();
        txn(8'h00, addr, n, 9, 99);
    endtask

    initial begin
        logic [7:0] op;
        int n;
        logic [31:0] a;
        for (int i = 0; i < MEM; i++) model_mem[i] = 8'hxx;
        rst_n = 1'b0; ce = 1'b1; sck = 1'b0; io_in = '0; dqs_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_io_en", {24'd0, io_en}, 32'd0);
        chk("rst_dqs_en", {31'd0, dqs_en}, 32'd0);
        chk("rst_io_out", {24'd0, io_out}, 32'd0);
        chk("rst_dqs_out", {31'd0, dqs_out}, 32'd0);
        rst_n = 1'b1;
        wait_half();

        set_w(8'hA5, 8'h5A, 8'h3C, 8'hC3, 4'b0000);
        txn(8'h80, 32'h10, 4, 9, 99);
        read_cap(32'h10, 4);
        want.push_back(9'h1A5); want.push_back(9'h05A);
        want.push_back(9'h13C); want.push_back(9'h0C3);
        chk_cap("rd_0x10");

        set_w(8'h11, 8'h22, 8'h00, 8'h00, 4'b0000);
        txn(8'h80, 32'h3FF, 2, 9, 99);
        read_cap(32'h3FF, 2);
        want.push_back(9'h111); want.push_back(9'h022);
        chk_cap("rd_wrap");
        read_cap(32'h0, 1);
        want.push_back(9'h122);
        chk_cap("rd_0x000");

        set_w(8'h01, 8'h02, 8'h03, 8'h04, 4'b0000);
        txn(8'h80, 32'h20, 4, 9, 99);
        set_w(8'h10, 8'h20, 8'h30, 8'h40, 4'b0010);
        txn(8'h80, 32'h20, 4, 9, 99);
        read_cap(32'h20, 4);
        want.push_back(9'h110); want.push_back(9'h002);
        want.push_back(9'h130); want.push_back(9'h040);
        chk_cap("rd_masked");

        set_w(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000);
        txn(8'h80, 32'h10, 4, 2, 99);
        set_w(8'h77, 8'h77, 8'h77, 8'h77, 4'b0000);
        txn(8'hC0, 32'h10, 4, 9, 99);
        read_cap(32'h10, 4);
        want.push_back(9'h1A5); want.push_back(9'h05A);
        want.push_back(9'h13C); want.push_back(9'h0C3);
        chk_cap("rd_after_abort");

        txn(8'h00, 32'h3FF, 6, 9, 2);
        read_cap(32'h3FF, 2);
        want.push_back(9'h111); want.push_back(9'h022);
        chk_cap("rd_after_rst");

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[9:0] = 10'h3F8 + 10'($urandom_range(0, 7));
            n = $urandom_range(1, 12);
            for (int i = 0; i < 16; i++) begin
                wbuf[i] = 8'($urandom);
                mbuf[i] = ($urandom_range(0, 4) == 0);
            end
            case ($urandom_range(0, 9))
                0: begin
                    op = 8'($urandom);
                    if (op == 8'h00 || op == 8'h80) op = 8'h40;
                end
                1, 2, 3, 4: op = 8'h80;
                default: op = 8'h00;
            endcase
            // Reads only from bytes the model already knows
            if (op == 8'h00) begin
                for (int i = 0; i < n; i++) begin
                    if ($isunknown(model_mem[(a + i) % MEM])) begin
                        model_mem[(a + i) % MEM] = 8'h00;
                        op = 8'h80;
                        mbuf[i] = 1'b0;
                    end
                end
            end
            txn(op, a, n, 9, 99);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psram_opi_slv.md
PSRAM_OPI_SLV -- requirements
Module: psram_opi_slv

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, byte-address width of internal array (2^MEM_AW bytes).
REQ-002 SHALL have parameter RD_LAT, default 5, read latency in sck rising edges.
REQ-003 SHALL have parameter WR_LAT, default 5, write latency in sck rising edges.
REQ-004 SHALL have parameter WCMD, default 8'h80, linear-burst write opcode.
REQ-005 SHALL have parameter RCMD, default 8'h00, linear-burst read opcode.
REQ-006 SHALL have port clk_i  in  1  sole clock; oversamples sck (sck period >= 4 clk_i).
REQ-007 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port psram_sck_i  in  1  controller serial clock.
REQ-009 SHALL have port psram_ce_i  in  1  chip enable, active-low.
REQ-010 SHALL have port psram_io_in_i  in  8  controller-driven DQ.
REQ-011 SHALL have port psram_dqs_in_i  in  1  write data mask (1 = byte masked).
REQ-012 SHALL have port psram_io_out_o  out  8  read data.
REQ-013 SHALL have port psram_io_en_o  out  8  DQ output enable, all-ones or all-zeros.
REQ-014 SHALL have port psram_dqs_out_o  out  1  read strobe.
REQ-015 SHALL have port psram_dqs_en_o  out  1  strobe output enable.

Function
REQ-016 SHALL register sck each clk_i and detect rise/fall edges; all protocol actions occur in the clk_i cycle an edge is detected, with io_in/dqs_in sampled in that cycle.
REQ-017 SHALL implement FSM IDLE, INST, ADDR, LATN, WDATA, RDATA, HOLD.
REQ-018 IDLE->INST on ce falling; INST captures opcode on first edge, ignores second (DDR 2-edge instruction), then ->ADDR.
REQ-019 ADDR SHALL shift in 4 bytes MSB-first over 4 edges; low MEM_AW bits form the start pointer; then ->LATN.
REQ-020 LATN SHALL count RD_LAT (RCMD) or WR_LAT (WCMD) sck rising edges, then ->RDATA or WDATA; unknown opcode ->HOLD after INST.
REQ-021 WDATA: each edge stores io_in to mem[ptr] unless dqs_in=1; ptr increments every edge, masked or not.
REQ-022 RDATA: each edge drives mem[ptr] on io_out 1 clk_i later, ptr increments; dqs_out = 1 for rise-edge bytes, 0 for fall-edge bytes; io_en/dqs_en high from LATN exit until ce rises.
REQ-023 Pointer SHALL wrap modulo 2^MEM_AW (last byte -> byte 0) with no gap.
REQ-024 ce rising in any state SHALL return FSM to IDLE next cycle, drop io_en/dqs_en, discard partial opcode/address; already-written bytes persist.
REQ-025 ce rising coincident with an sck edge: the edge is ignored.
REQ-026 HOLD ignores all edges until ce rises.
REQ-027 Memory read SHALL be combinational from array; write synchronous.

Reset
REQ-028 On rst_n_i low: FSM=IDLE, io_out=0, io_en=0, dqs_out=0, dqs_en=0, counters/pointer=0; memory contents not reset.
REQ-029 Reset mid-burst SHALL abort immediately; after release, a new transaction requires a fresh ce falling edge.

Configuration
REQ-030 Macro PSRAM_SLV_MR_EN: when defined, SHALL support 8-byte mode-register file: opcode 8'hC0 writes, 8'h40 reads MR[addr[2:0]], zero latency, same DDR data rules, index wraps at 8; MR reset to 0.
REQ-031 Without PSRAM_SLV_MR_EN, 8'hC0/8'h40 SHALL be unknown opcodes (->HOLD) and no MR storage exists.

Structure
REQ-032 FSM state enum, opcode constants and default latencies SHALL live in shared package psram_pkg.
REQ-033 Byte array SHALL be sub-module psram_slv_mem (2^MEM_AW x 8, async read, sync write).

Verification
REQ-034 Write 8'h80, addr 0x10, WR_LAT=5, bytes A5,5A,3C,C3 -> mem[0x10..0x13]=A5,5A,3C,C3.
REQ-035 Read 8'h00 addr 0x10 after REQ-034 -> io_out A5,5A,3C,C3 on consecutive edges, dqs_out 1,0,1,0, io_en=FF only during data.
REQ-036 Write at addr 0x3FF, bytes 11,22 with MEM_AW=10 -> mem[0x3FF]=11, mem[0x000]=22.
REQ-037 Write 4 bytes with dqs_in=1 on 2nd byte -> that location unchanged, others written.
REQ-038 ce high after 2 address bytes, then valid read -> no memory change, read returns correct data; opcode 8'hC0 without macro -> outputs stay disabled.
REQ-039 rst_n_i low mid-read -> io_en=0, dqs_en=0 same cycle; next read correct.
